// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with frame-boundary shadow updates.
// Optional anti-ghosting dead time at the start of each digit slot: define SEG7_GHOST_BLANK_EN.

module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic        load,
    output logic        load_pending,
    output logic [7:0]  Enable,
    output logic [7:0]  SevenSeg,
    output logic        frame_done
);

    localparam int            PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_r;
    logic [2:0]    idx_r;

    logic [31:0]   stage_data_r;
    logic [7:0]    stage_en_r;
    logic [7:0]    stage_dp_r;
    logic [31:0]   shadow_data_r;
    logic [7:0]    shadow_en_r;
    logic [7:0]    shadow_dp_r;
    logic          load_pending_r;

    logic          frame_done_r;
    logic [7:0]    enable_r;
    logic [7:0]    seg_r;

    logic          tick_s;
    logic          boundary_s;
    logic          blank_s;
    logic          lit_s;
    logic [3:0]    nib_s;
    logic [7:0]    enable_nxt_s;
    logic [7:0]    seg_nxt_s;

    // Hex nibble to active-high gfedcba segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h27;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Slot tick and frame boundary decode.
    always_comb begin
        tick_s     = (prescaler_r == PRESC_LAST);
        boundary_s = tick_s && (idx_r == 3'd7);
    end

    // Prescaler and digit index; scanning never stops, lit or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_r <= {PW{1'b0}};
            idx_r       <= 3'd0;
        end else if (tick_s) begin
            prescaler_r <= {PW{1'b0}};
            idx_r       <= idx_r + 3'd1;
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    // Staging capture and boundary-only shadow update; a load landing on the
    // boundary bypasses staging so it reaches the very next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data_r   <= 32'h0000_0000;
            stage_en_r     <= 8'h00;
            stage_dp_r     <= 8'h00;
            shadow_data_r  <= 32'h0000_0000;
            shadow_en_r    <= 8'h00;
            shadow_dp_r    <= 8'h00;
            load_pending_r <= 1'b0;
        end else if (boundary_s) begin
            if (load) begin
                shadow_data_r <= digit_data;
                shadow_en_r   <= digit_en;
                shadow_dp_r   <= dp;
            end else if (load_pending_r) begin
                shadow_data_r <= stage_data_r;
                shadow_en_r   <= stage_en_r;
                shadow_dp_r   <= stage_dp_r;
            end
            load_pending_r <= 1'b0;
        end else if (load) begin
            stage_data_r   <= digit_data;
            stage_en_r     <= digit_en;
            stage_dp_r     <= dp;
            load_pending_r <= 1'b1;
        end
    end

    // One-cycle pulse marking the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
        end
    end

`ifdef SEG7_GHOST_BLANK_EN
    // Dead time at the head of each slot lets the previous digit's drivers discharge.
    always_comb begin
        blank_s = (prescaler_r < PW'(BLANK_CYCLES));
    end
`else
    // No dead time in this build.
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Next digit-select and segment pattern for the slot currently being scanned.
    always_comb begin
        enable_nxt_s = 8'h00;
        seg_nxt_s    = 8'h00;
        nib_s        = shadow_data_r[{idx_r, 2'b00} +: 4];
        lit_s        = shadow_en_r[idx_r] & ~blank_s;
        if (lit_s) begin
            enable_nxt_s = 8'h01 << idx_r;
            seg_nxt_s    = {shadow_dp_r[idx_r], seg_decode(nib_s)};
        end else begin
            enable_nxt_s = 8'h00;
            seg_nxt_s    = 8'h00;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_r <= 8'h00;
            seg_r    <= 8'h00;
        end else begin
            enable_r <= enable_nxt_s;
            seg_r    <= seg_nxt_s;
        end
    end

    assign load_pending = load_pending_r;
    assign Enable       = enable_r;
    assign SevenSeg     = seg_r;
    assign frame_done   = frame_done_r;

    seg7_scan_checker #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable_r),
        .seven_seg  (seg_r),
        .frame_done (frame_done_r)
    );

endmodule

// Runtime invariants of the scan driver outputs.
module seg7_scan_checker #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic       clk,
    input logic       rst,
    input logic [7:0] enable,
    input logic [7:0] seven_seg,
    input logic       frame_done
);

    a_onehot_enable: assert property (@(posedge clk) disable iff (rst)
        $onehot0(enable));

    a_dark_segments: assert property (@(posedge clk) disable iff (rst)
        (enable == 8'h00) |-> (seven_seg == 8'h00));

    a_single_pulse: assert property (@(posedge clk) disable iff (rst)
        frame_done |=> !frame_done);

    a_config: assert property (@(posedge clk)
        (REFRESH_DIV >= 2) && (BLANK_CYCLES < REFRESH_DIV));

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + randomized bench for seg7_scan_driver against a frame-level reference model.
module tb_seg7_scan_driver;

`ifdef SEG7_GHOST_BLANK_EN
    localparam int DIV   = 8;
    localparam bit GHOST = 1'b1;
`else
    localparam int DIV   = 4;
    localparam bit GHOST = 1'b0;
`endif
    localparam int BLANK = 2;
    localparam int OFS   = GHOST ? BLANK : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] digit_data = 32'h0;
    logic [7:0]  digit_en = 8'h0;
    logic [7:0]  dp = 8'h0;
    logic        load_pending;
    logic [7:0]  Enable;
    logic [7:0]  SevenSeg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .digit_data(digit_data), .digit_en(digit_en),
        .dp(dp), .load(load), .load_pending(load_pending), .Enable(Enable),
        .SevenSeg(SevenSeg), .frame_done(frame_done)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycle position within the frame plus the displayed and queued frames.
    int          cyc = 0;
    logic [31:0] m_sh_d = 32'h0, m_st_d = 32'h0;
    logic [7:0]  m_sh_e = 8'h0, m_sh_p = 8'h0, m_st_e = 8'h0, m_st_p = 8'h0;
    logic        m_pend = 1'b0;
    logic [7:0]  x_en = 8'h0, x_seg = 8'h0;
    logic        x_fd = 1'b0, x_pend = 1'b0;

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bnd_next();
        return ((cyc % DIV) == DIV - 1) && (((cyc / DIV) % 8) == 7);
    endfunction

    task automatic model_edge();
        int pre;
        int id;
        bit bnd;
        bit lit;
        if (rst) begin
            cyc = 0;
            m_sh_d = 32'h0; m_sh_e = 8'h0; m_sh_p = 8'h0;
            m_st_d = 32'h0; m_st_e = 8'h0; m_st_p = 8'h0;
            m_pend = 1'b0;
            x_en = 8'h0; x_seg = 8'h0; x_fd = 1'b0;
        end else begin
            pre = cyc % DIV;
            id  = (cyc / DIV) % 8;
            bnd = (pre == DIV - 1) && (id == 7);
            lit = m_sh_e[id] && !(GHOST && (pre < BLANK));
            x_en  = lit ? (8'h01 << id) : 8'h00;
            x_seg = lit ? {m_sh_p[id], seg_tab[m_sh_d[4*id +: 4]]} : 8'h00;
            x_fd  = bnd;
            if (bnd) begin
                if (load) begin
                    m_sh_d = digit_data; m_sh_e = digit_en; m_sh_p = dp;
                end else if (m_pend) begin
                    m_sh_d = m_st_d; m_sh_e = m_st_e; m_sh_p = m_st_p;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_st_d = digit_data; m_st_e = digit_en; m_st_p = dp;
                m_pend = 1'b1;
            end
            cyc = (cyc + 1) % (8 * DIV);
        end
        x_pend = m_pend;
    endtask

    task automatic step(input logic l, input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        load = l; digit_data = d; digit_en = e; dp = p;
        model_edge();
        @(posedge clk);
        #1;
        check("enable", {24'h0, Enable}, {24'h0, x_en});
        check("sevenseg", {24'h0, SevenSeg}, {24'h0, x_seg});
        check("frame_done", {31'h0, frame_done}, {31'h0, x_fd});
        check("load_pending", {31'h0, load_pending}, {31'h0, x_pend});
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_fd();
        bit got = 1'b0;
        for (int i = 0; i < 8 * DIV + 2 && !got; i++) begin
            idle(1);
            if (frame_done === 1'b1) got = 1'b1;
        end
        check("frame_done_seen", {31'h0, got}, 32'h1);
    endtask

    task automatic check_out(input string tag, input logic [7:0] en, input logic [7:0] sg);
        check({tag, "_enable"}, {24'h0, Enable}, {24'h0, en});
        check({tag, "_seg"}, {24'h0, SevenSeg}, {24'h0, sg});
    endtask

    initial begin
        int fd_cnt;

        // Reset, with a load that must be ignored.
        rst = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
        idle(2);
        check_out("reset", 8'h00, 8'h00);
        check("reset_pending", {31'h0, load_pending}, 32'h0);
        check("reset_fd", {31'h0, frame_done}, 32'h0);
        rst = 1'b0;

        // Dark display while idle; frame_done still pulses.
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (frame_done === 1'b1) fd_cnt++;
        end
        check("fd_count_40", fd_cnt, 40 / (8 * DIV));

        // Basic frame load.
        step(1'b1, 32'h7654_3210, 8'hFF, 8'h01);
        check("load_pending_set", {31'h0, load_pending}, 32'h1);
        wait_fd();
        idle(1 + OFS);
        check_out("digit0", 8'h01, 8'hBF);
        idle(DIV);
        check_out("digit1", 8'h02, 8'h06);
        idle(6 * DIV);
        check_out("digit7", 8'h80, 8'h27);

        // Two loads in one frame: last wins.
        wait_fd();
        idle(2);
        step(1'b1, 32'h7654_321A, 8'hFF, 8'h00);
        idle(1);
        step(1'b1, 32'h7654_321F, 8'hFF, 8'h00);
        check("pending_two_loads", {31'h0, load_pending}, 32'h1);
        wait_fd();
        check("pending_cleared", {31'h0, load_pending}, 32'h0);
        idle(1 + OFS);
        check_out("last_load_wins", 8'h01, 8'h71);

        // Load exactly on the boundary cycle.
        for (int i = 0; i < 8 * DIV && !bnd_next(); i++) idle(1);
        check("boundary_reached", {31'h0, bnd_next()}, 32'h1);
        step(1'b1, 32'h0000_000E, 8'hFF, 8'h00);
        check("boundary_no_pending", {31'h0, load_pending}, 32'h0);
        check("boundary_fd", {31'h0, frame_done}, 32'h1);
        idle(1 + OFS);
        check_out("boundary_load", 8'h01, 8'h79);

        // Digit 0 blanked via digit_en.
        idle(2);
        step(1'b1, 32'h7654_3210, 8'hFE, 8'h00);
        wait_fd();
        idle(1 + OFS);
        check_out("blank_digit0", 8'h00, 8'h00);
        idle(DIV);
        check_out("blank_digit1", 8'h02, 8'h06);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) == 0, $urandom, 8'($urandom), 8'($urandom));

        // Reset mid-frame discards a pending load.
        wait_fd();
        idle(3);
        step(1'b1, 32'h1111_1111, 8'hFF, 8'hFF);
        check("pending_before_rst", {31'h0, load_pending}, 32'h1);
        rst = 1'b1;
        idle(1);
        check("rst_enable", {24'h0, Enable}, 32'h0);
        check("rst_pending", {31'h0, load_pending}, 32'h0);
        rst = 1'b0;
        idle(3 * 8 * DIV);
        check_out("post_rst_dark", 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
